pyrite_bpi_flash_seq: RTL and testbench

Hardware sequencer for parallel NOR (BPI) flash bus cycles. It sits downstream of the Pyrite VPD flash-control register block. A single command (read or write one word) is accepted over a valid/ready handshake. The block then generates correctly timed ce_n/adv_n/oe_n/we_n/dq_oe waveforms, so software no longer needs one config-space access per pin edge. Read data or a write acknowledgment is returned as a single-cycle response pulse.

---
 rtl/pyrite_bpi_pkg.sv | 31 +++
 rtl/pyrite_bpi_flash_seq.sv | 196 +++++++++++++++++++
 tb/tb_pyrite_bpi_flash_seq.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pyrite_bpi_pkg.sv
// Shared types and default timing for the BPI flash bus-cycle sequencer.
package pyrite_bpi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StSetup,
    StPulse,
    StHold
  } bpi_state_e;

  localparam int unsigned DefAdvCyc   = 2;
  localparam int unsigned DefSetupCyc = 1;
  localparam int unsigned DefRdCyc    = 8;
  localparam int unsigned DefWrCyc    = 4;
  localparam int unsigned DefHoldCyc  = 2;

  // The counter only ever holds N-1, so clog2 of the largest phase is enough.
  function automatic int unsigned cnt_width(input int unsigned adv, input int unsigned setup,
                                            input int unsigned rd, input int unsigned wr,
                                            input int unsigned hold);
    int unsigned m;
    m = adv;
    if (setup > m) m = setup;
    if (rd > m) m = rd;
    if (wr > m) m = wr;
    if (hold > m) m = hold;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pyrite_bpi_flash_seq.sv
// Single-word read/write sequencer generating timed ce_n/adv_n/oe_n/we_n strobes for BPI flash.
module pyrite_bpi_flash_seq
  import pyrite_bpi_pkg::*;
#(
  parameter int unsigned FLASH_ADDR_W = 23,
  parameter int unsigned FLASH_DATA_W = 16,
  parameter int unsigned FLASH_RGN_W  = 1,
  parameter int unsigned ADV_CYC      = DefAdvCyc,
  parameter int unsigned SETUP_CYC    = DefSetupCyc,
  parameter int unsigned RD_CYC       = DefRdCyc,
  parameter int unsigned WR_CYC       = DefWrCyc,
  parameter int unsigned HOLD_CYC     = DefHoldCyc
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [FLASH_ADDR_W-1:0] cmd_addr,
  input  logic [FLASH_RGN_W-1:0]  cmd_region,
  input  logic [FLASH_DATA_W-1:0] cmd_wdata,
  output logic                    rsp_valid,
  output logic [FLASH_DATA_W-1:0] rsp_rdata,
  input  logic [FLASH_DATA_W-1:0] flash_dq_i,
  output logic [FLASH_DATA_W-1:0] flash_dq_o,
  output logic                    flash_dq_oe,
  output logic [FLASH_ADDR_W-1:0] flash_addr,
  output logic [FLASH_RGN_W-1:0]  flash_region,
  output logic                    flash_region_oe,
  output logic                    flash_ce_n,
  output logic                    flash_oe_n,
  output logic                    flash_we_n,
  output logic                    flash_adv_n
);

  localparam int unsigned CntW = cnt_width(ADV_CYC, SETUP_CYC, RD_CYC, WR_CYC, HOLD_CYC);
  typedef logic [CntW-1:0] cnt_t;

  function automatic cnt_t ld(input int unsigned n);
    return cnt_t'(n - 1);
  endfunction

  bpi_state_e              state_q, state_d;
  cnt_t                    cnt_q, cnt_d;
  logic                    write_q, write_d;
  logic [FLASH_DATA_W-1:0] wdata_q, wdata_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [FLASH_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [FLASH_DATA_W-1:0] dq_o_q, dq_o_d;
  logic                    dq_oe_q, dq_oe_d;
  logic [FLASH_ADDR_W-1:0] addr_q, addr_d;
  logic [FLASH_RGN_W-1:0]  region_q, region_d;
  logic                    region_oe_q, region_oe_d;
  logic                    ce_n_q, ce_n_d;
  logic                    oe_n_q, oe_n_d;
  logic                    we_n_q, we_n_d;
  logic                    adv_n_q, adv_n_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    dq_o_d      = dq_o_q;
    dq_oe_d     = dq_oe_q;
    addr_d      = addr_q;
    region_d    = region_q;
    region_oe_d = region_oe_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    adv_n_d     = adv_n_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          write_d     = cmd_write;
          wdata_d     = cmd_wdata;
          addr_d      = cmd_addr;
          region_d    = cmd_region;
          region_oe_d = 1'b1;
          ce_n_d      = 1'b0;
          adv_n_d     = 1'b0;
          cmd_ready_d = 1'b0;
          cnt_d       = ld(ADV_CYC);
          state_d     = StAddr;
        end
      end
      StAddr: begin
        if (cnt_q == '0) begin
          adv_n_d = 1'b1;
          // Write data goes on the bus a full setup phase ahead of we_n.
          if (write_q) begin
            dq_o_d  = wdata_q;
            dq_oe_d = 1'b1;
          end
          cnt_d   = ld(SETUP_CYC);
          state_d = StSetup;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          if (write_q) we_n_d = 1'b0;
          else         oe_n_d = 1'b0;
          cnt_d   = ld(write_q ? WR_CYC : RD_CYC);
          state_d = StPulse;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      StPulse: begin
        if (cnt_q == '0) begin
          // Sampled without a synchronizer; RD_CYC must cover access time plus IO delay.
          if (!write_q) rsp_rdata_d = flash_dq_i;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          cnt_d   = ld(HOLD_CYC);
          state_d = StHold;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          ce_n_d      = 1'b1;
          dq_oe_d     = 1'b0;
          region_oe_d = 1'b0;
          rsp_valid_d = 1'b1;
          cmd_ready_d = 1'b1;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      dq_o_q      <= '0;
      dq_oe_q     <= 1'b0;
      addr_q      <= '0;
      region_q    <= '0;
      region_oe_q <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      adv_n_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      dq_o_q      <= dq_o_d;
      dq_oe_q     <= dq_oe_d;
      addr_q      <= addr_d;
      region_q    <= region_d;
      region_oe_q <= region_oe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      adv_n_q     <= adv_n_d;
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign flash_dq_o      = dq_o_q;
  assign flash_dq_oe     = dq_oe_q;
  assign flash_addr      = addr_q;
  assign flash_region    = region_q;
  assign flash_region_oe = region_oe_q;
  assign flash_ce_n      = ce_n_q;
  assign flash_oe_n      = oe_n_q;
  assign flash_we_n      = we_n_q;
  assign flash_adv_n     = adv_n_q;

endmodule

// File: tb/tb_pyrite_bpi_flash_seq.sv
// Directed and random bench for pyrite_bpi_flash_seq with a latency/data scoreboard.
module tb_pyrite_bpi_flash_seq;

  localparam int AW  = 23;
  localparam int DW  = 16;
  localparam int RW  = 1;
  localparam int ADV = 2;
  localparam int SET = 1;
  localparam int RD  = 8;
  localparam int WR  = 4;
  localparam int HLD = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [RW-1:0] cmd_region = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [DW-1:0] model_rd = '0;
  logic [DW-1:0] flash_dq_o;
  logic          flash_dq_oe;
  logic [AW-1:0] flash_addr;
  logic [RW-1:0] flash_region;
  logic          flash_region_oe, flash_ce_n, flash_oe_n, flash_we_n, flash_adv_n;

  pyrite_bpi_flash_seq #(
    .FLASH_ADDR_W(AW), .FLASH_DATA_W(DW), .FLASH_RGN_W(RW),
    .ADV_CYC(ADV), .SETUP_CYC(SET), .RD_CYC(RD), .WR_CYC(WR), .HOLD_CYC(HLD)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_region(cmd_region), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .flash_dq_i(model_rd), .flash_dq_o(flash_dq_o), .flash_dq_oe(flash_dq_oe),
    .flash_addr(flash_addr), .flash_region(flash_region),
    .flash_region_oe(flash_region_oe), .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n),
    .flash_we_n(flash_we_n), .flash_adv_n(flash_adv_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] rdata;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_checks = 0;
  int n_fail = 0;
  logic [DW-1:0] last_rd = '0;
  logic [DW-1:0] model_wr = '0;
  logic [AW-1:0] model_wr_addr = '0;

  int adv_run = 0, oe_run = 0, we_run = 0, dqoe_run = 0, regoe_run = 0, celo_run = 0;
  int cehi_run = 0;
  int adv_w = 0, oe_w = 0, we_w = 0, dqoe_w = 0, regoe_w = 0, celo_w = 0, cehi_w = 0;
  int oe_total = 0;
  logic rsp_prev = 1'b0;
  logic we_prev = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: invariants, scoreboard pop, flash write model and strobe pulse widths.
  always @(negedge clk) begin
    if (rst) begin
      adv_run = 0; oe_run = 0; we_run = 0; dqoe_run = 0; regoe_run = 0; celo_run = 0;
      cehi_run = 0; rsp_prev = 1'b0; we_prev = 1'b1;
    end else begin
      check("oe_we_excl", 32'(flash_oe_n | flash_we_n), 32'd1);
      check("dqoe_vs_oe", 32'(flash_dq_oe & ~flash_oe_n), 32'd0);
      check("adv_needs_ce", 32'(~flash_adv_n & flash_ce_n), 32'd0);
      check("rsp_single", 32'(rsp_valid & rsp_prev), 32'd0);
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_latency", cyc, mon_e.cyc);
          check("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
        end
      end
      if (!we_prev && flash_we_n && flash_dq_oe) begin
        model_wr      = flash_dq_o;
        model_wr_addr = flash_addr;
      end
      if (!flash_adv_n) adv_run++; else if (adv_run != 0) begin adv_w = adv_run; adv_run = 0; end
      if (!flash_oe_n) begin oe_run++; oe_total++; end
      else if (oe_run != 0) begin oe_w = oe_run; oe_run = 0; end
      if (!flash_we_n) we_run++; else if (we_run != 0) begin we_w = we_run; we_run = 0; end
      if (flash_dq_oe) dqoe_run++; else if (dqoe_run != 0) begin dqoe_w = dqoe_run; dqoe_run = 0; end
      if (flash_region_oe) regoe_run++;
      else if (regoe_run != 0) begin regoe_w = regoe_run; regoe_run = 0; end
      if (!flash_ce_n) begin
        celo_run++;
        if (cehi_run != 0) begin cehi_w = cehi_run; cehi_run = 0; end
      end else begin
        cehi_run++;
        if (celo_run != 0) begin celo_w = celo_run; celo_run = 0; end
      end
      rsp_prev = rsp_valid;
      we_prev  = flash_we_n;
    end
  end

  // Driver steps sit just after the monitor's sampling point.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input bit w, input logic [AW-1:0] a, input logic [RW-1:0] r,
                      input logic [DW-1:0] d, input logic [DW-1:0] rv, input bit hold,
                      input bit b2b);
    int n;
    exp_t e;
    n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_region = r; cmd_wdata = d;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    if (b2b) check("b2b_rsp_with_ready", 32'(rsp_valid), 32'd1);
    if (!w) begin
      model_rd = rv;
      last_rd  = rv;
    end
    e.rdata = last_rd;
    e.cyc   = cyc + 1 + ADV + SET + (w ? WR : RD) + HLD;
    sb.push_back(e);
    tick();
    if (!hold) cmd_valid = 1'b0;
    check("busy_ready_low", 32'(cmd_ready), 32'd0);
    if (b2b) check("ce_gap", cehi_w, 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    check("sb_drained", sb.size(), 32'd0);
    tick();
  endtask

  initial begin
    int oe_before;
    int acc;
    bit w;
    repeat (3) tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_dq_o", 32'(flash_dq_o), 32'd0);
    check("rst_dq_oe", 32'(flash_dq_oe), 32'd0);
    check("rst_addr", 32'(flash_addr), 32'd0);
    check("rst_region", 32'(flash_region), 32'd0);
    check("rst_region_oe", 32'(flash_region_oe), 32'd0);
    check("rst_strobes", 32'({flash_ce_n, flash_oe_n, flash_we_n, flash_adv_n}), 32'hF);
    rst = 1'b0;
    repeat (3) tick();
    check("idle_no_activity", 32'({cmd_ready, flash_ce_n}), 32'h3);

    // Read with region bit set.
    send(1'b0, 23'h12345, 1'b1, 16'h0, 16'hBEEF, 1'b0, 1'b0);
    check("rd_addr", 32'(flash_addr), 32'h12345);
    check("rd_region", 32'(flash_region), 32'd1);
    check("rd_ce_adv", 32'({flash_ce_n, flash_adv_n, flash_region_oe}), 32'h1);
    wait_idle();
    check("rd_adv_width", adv_w, ADV);
    check("rd_oe_width", oe_w, RD);
    check("rd_regoe_width", regoe_w, ADV + SET + RD + HLD);
    check("rd_ce_width", celo_w, ADV + SET + RD + HLD);

    // Write: oe_n must never fall.
    oe_before = oe_total;
    send(1'b1, 23'h0, 1'b0, 16'h00E8, 16'h0, 1'b0, 1'b0);
    wait_idle();
    check("wr_we_width", we_w, WR);
    check("wr_dqoe_width", dqoe_w, SET + WR + HLD);
    check("wr_model_data", 32'(model_wr), 32'h00E8);
    check("wr_model_addr", 32'(model_wr_addr), 32'h0);
    check("wr_no_oe", oe_total, oe_before);
    check("wr_ce_width", celo_w, ADV + SET + WR + HLD);

    // Inputs changed mid-operation must not reach the pins.
    send(1'b1, 23'h000AA, 1'b0, 16'h1234, 16'h0, 1'b0, 1'b0);
    cmd_addr  = '1;
    cmd_wdata = 16'hFFFF;
    wait_idle();
    check("stable_wdata", 32'(model_wr), 32'h1234);
    check("stable_waddr", 32'(model_wr_addr), 32'hAA);
    check("stable_pin_addr", 32'(flash_addr), 32'hAA);

    // cmd_valid held across four back-to-back commands.
    send(1'b0, 23'h100, 1'b0, 16'h0, 16'h1111, 1'b1, 1'b0);
    send(1'b1, 23'h200, 1'b1, 16'hCAFE, 16'h0, 1'b1, 1'b1);
    send(1'b0, 23'h300, 1'b0, 16'h0, 16'h2222, 1'b1, 1'b1);
    send(1'b1, 23'h400, 1'b0, 16'h0F0F, 16'h0, 1'b0, 1'b1);
    wait_idle();
    check("b2b_last_write", 32'(model_wr), 32'h0F0F);

    // Reset in the third read-pulse cycle drops the command.
    send(1'b0, 23'h555, 1'b1, 16'h0, 16'h5A5A, 1'b0, 1'b0);
    acc = cyc;
    repeat (5) tick();
    check("mid_rst_cycle", cyc, acc + 5);
    check("mid_rst_in_pulse", 32'(flash_oe_n), 32'd0);
    rst = 1'b1;
    tick();
    check("mid_rst_strobes", 32'({flash_ce_n, flash_oe_n, flash_we_n, flash_adv_n}), 32'hF);
    check("mid_rst_dq_oe", 32'(flash_dq_oe), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_rsp", 32'({rsp_valid, rsp_rdata}), 32'd0);
    sb.delete();
    last_rd = '0;
    rst = 1'b0;
    repeat (16) tick();
    check("post_rst_idle", 32'({cmd_ready, flash_ce_n}), 32'h3);

    // Random command stream; the monitor checks invariants and scoreboard.
    for (int i = 0; i < 12; i++) begin
      w = 1'($urandom_range(0, 1));
      send(w, AW'($urandom), RW'($urandom), DW'($urandom), DW'($urandom), 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
